// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO feeding a combinational 3-bit ALU, one op
// in flight, result captured into a registered valid/ready output slot.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_data/valid/ready   packed command {sel,B,A} with valid/ready handshake
//   alu_a/alu_b/alu_sel   registered operands/opcode driven to the ALU
//   alu_result            combinational ALU result
//   out_result/out_sel    captured result and the opcode that produced it
//   out_valid/out_ready   output slot handshake
//   count                 FIFO occupancy 0..DEPTH
//   busy                  op in flight or commands queued
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int A_W   = 3,
    parameter int B_W   = 3,
    parameter int SEL_W = 2,
    parameter int RES_W = 6,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH),
    localparam int DW   = SEL_W + B_W + A_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [A_W-1:0]   alu_a,
    output logic [B_W-1:0]   alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [RES_W-1:0] alu_result,
    output logic [RES_W-1:0] out_result,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t            state_q;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [A_W-1:0]    alu_a_q;
    logic [B_W-1:0]    alu_b_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic [RES_W-1:0]  out_result_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic              out_valid_q;

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty = (count_q != '0);

    // Full blocks pushes even when a pop happens on the same edge.
    assign in_ready = (count_q != FULL) & ~rst;
    assign push     = in_valid & in_ready;

    // Head is taken from IDLE, or from HOLD once the consumer frees the slot.
    assign pop = not_empty &
                 ((state_q == IDLE) | ((state_q == HOLD) & out_ready));

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            out_result_q <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                {alu_sel_q, alu_b_q, alu_a_q} <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            unique case (state_q)
                IDLE: begin
                    if (not_empty) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_result_q <= alu_result;
                    out_sel_q    <= alu_sel_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= not_empty ? ISSUE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign out_result = out_result_q;
    assign out_sel    = out_sel_q;
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign busy       = (state_q != IDLE) | not_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic,
// compared each cycle against a transaction-level queue model.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;
    logic [5:0] out_result;
    logic [1:0] out_sel;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       busy;

    always #5 clk = ~clk;

    // ALU stub: 6-bit product of the operands.
    assign alu_result = {3'b000, alu_a} * {3'b000, alu_b};

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_result(alu_result),
        .out_result(out_result),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: queued commands, the single in-flight command and whether
    // its result is already presented in the output slot.
    logic [7:0] mq[$];
    logic [7:0] cur;
    bit         inflight;
    bit         shown;
    logic [7:0] m_alu;
    logic [5:0] m_res;
    logic [1:0] m_sel;
    bit         m_outv;
    bit         m_acc;

    function automatic logic [5:0] prod(input logic [7:0] c);
        return 6'(int'(c[2:0]) * int'(c[5:3]));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  n;
        bit  free;
        n     = mq.size();
        free  = 0;
        m_acc = 0;
        if (rst) begin
            mq.delete();
            inflight = 0;
            shown    = 0;
            m_alu    = '0;
            m_res    = '0;
            m_sel    = '0;
            m_outv   = 0;
        end else begin
            m_acc = in_valid && (n < DEPTH);
            if (!inflight) begin
                free = 1;
            end else if (!shown) begin
                m_res  = prod(cur);
                m_sel  = cur[7:6];
                m_outv = 1;
                shown  = 1;
            end else if (out_ready) begin
                m_outv   = 0;
                inflight = 0;
                shown    = 0;
                free     = 1;
            end
            if (free && n > 0) begin
                cur      = mq.pop_front();
                inflight = 1;
                m_alu    = cur;
            end
            if (m_acc) mq.push_back(in_data);
        end
    endtask

    task automatic check_all();
        chk("count", int'(count), mq.size());
        chk("in_ready", int'(in_ready), int'(!rst && mq.size() < DEPTH));
        chk("alu_a", int'(alu_a), int'(m_alu[2:0]));
        chk("alu_b", int'(alu_b), int'(m_alu[5:3]));
        chk("alu_sel", int'(alu_sel), int'(m_alu[7:6]));
        chk("out_valid", int'(out_valid), int'(m_outv));
        chk("out_result", int'(out_result), int'(m_res));
        chk("out_sel", int'(out_sel), int'(m_sel));
        chk("busy", int'(busy), int'(inflight || mq.size() > 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int         acc;
        logic [7:0] first;
        logic [7:0] cmd;
        bit         done;

        inflight = 0;
        shown    = 0;
        m_alu    = '0;
        m_res    = '0;
        m_sel    = '0;
        m_outv   = 0;
        cur      = '0;

        // Reset with a command offered: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        out_ready = 1'b0;
        step();
        step();
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Single op with documented latency.
        #1;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'b01_010_011;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("single_alu_a", int'(alu_a), 3);
        chk("single_alu_b", int'(alu_b), 2);
        chk("single_alu_sel", int'(alu_sel), 1);
        step();
        chk("single_out_valid", int'(out_valid), 1);
        chk("single_out_result", int'(out_result), 6);
        chk("single_out_sel", int'(out_sel), 1);
        step();
        chk("single_out_drop", int'(out_valid), 0);

        // Fill under backpressure: 4 queued plus 1 in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        first     = in_data;
        acc       = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (m_acc) begin
                acc++;
                in_data = 8'($urandom);
            end
        end
        chk("fill_accepted", acc, 5);
        chk("fill_count", int'(count), 4);
        chk("fill_in_ready", int'(in_ready), 0);

        // Output slot must hold steady while out_ready is low.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_result", int'(out_result), int'(prod(first)));
        end

        // Full with pop: no push this edge, pushed the next one.
        out_ready = 1'b1;
        step();
        chk("fullpop_count", int'(count), 3);
        step();
        chk("fullpop_refill", int'(count), 4);

        // Drain in order, bounded.
        in_valid = 1'b0;
        done     = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (!busy && !out_valid) done = 1;
        end
        chk("drain_done", int'(done), 1);

        // Reset while holding a result with 3 queued.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("mid_count", int'(count), 3);
        chk("mid_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        cmd      = 8'($urandom);
        in_data  = cmd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_result", int'(out_result), int'(prod(cmd)));

        // Random traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(99) == 0);
            in_valid  = ($urandom_range(2) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(1) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
